flag_cond_unit: RTL and testbench

- Parametrised successor to the single-register flags/condition block.
- Holds NUM_FSETS independent flag sets, each written by the ALU.
- Resolves conditional jumps (stored flags) and fused compare-branches (live flags) through a one-entry registered valid/ready stage.
- Sits between decode/ALU and PC control; res_taken drives PC write.

---
 rtl/flag_cond_unit_if.sv | 84 ++++++++
 rtl/flag_cond_unit.sv | 167 ++++++++++++++++
 tb/tb_flag_cond_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flag_cond_unit_if.sv
// Shared definitions and port bundle for flag_cond_unit.
// Contents: condition-code encodings, the FLAGS_t flag word, and the
// flag-write / resolve-request / result bundle.
//
// Handshake contract:
//   - Request side: a request transfers on a CLK edge where req_valid and
//     req_ready are both high. While req_valid is high, the request fields
//     stay stable until that transfer.
//   - Result side: a result transfers on an edge where res_valid and
//     res_ready are both high. While res_valid is high, all res_* stay
//     stable until that transfer.
`ifndef FLAG_COND_DEFS
`define FLAG_COND_DEFS
`define COND_WIRENUM 4
`define COND_NOP 4'd0
`define COND_E   4'd1
`define COND_NE  4'd2
`define COND_A   4'd3
`define COND_B   4'd4
`define COND_AE  4'd5
`define COND_BE  4'd6
`define COND_G   4'd7
`define COND_L   4'd8
`define COND_GE  4'd9
`define COND_LE  4'd10
`define COND_S   4'd11
`define COND_NS  4'd12
`define COND_O   4'd13
`define COND_NO  4'd14
`endif

package flag_cond_pkg;
  typedef struct packed {
    logic zf;
    logic cf;
    logic sf;
    logic of;
  } FLAGS_t;
endpackage

interface flag_cond_unit_if #(
  parameter int NUM_FSETS = 4,
  parameter int FS_IDX_W  = (NUM_FSETS > 1) ? $clog2(NUM_FSETS) : 1,
  parameter int PC_W      = 32
);
  import flag_cond_pkg::*;

  logic                     flags_wr;
  logic [FS_IDX_W-1:0]      flags_wr_idx;
  FLAGS_t                   flags_in;
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_jump;
  logic                     req_branch;
  logic [`COND_WIRENUM-1:0] req_cond;
  logic [FS_IDX_W-1:0]      req_fidx;
  FLAGS_t                   req_flags;
  logic [PC_W-1:0]          req_pc;
  logic [PC_W-1:0]          req_target;
  logic                     res_valid;
  logic                     res_ready;
  logic                     res_taken;
  logic [PC_W-1:0]          res_target;
  logic                     res_mispredict;
  logic                     pred_taken;

  // Decode/ALU/PC-control side.
  modport master (
    output flags_wr, flags_wr_idx, flags_in,
    output req_valid, req_jump, req_branch, req_cond, req_fidx, req_flags,
    output req_pc, req_target, res_ready,
    input  req_ready, res_valid, res_taken, res_target, res_mispredict,
    input  pred_taken
  );

  // The flag/condition unit itself.
  modport slave (
    input  flags_wr, flags_wr_idx, flags_in,
    input  req_valid, req_jump, req_branch, req_cond, req_fidx, req_flags,
    input  req_pc, req_target, res_ready,
    output req_ready, res_valid, res_taken, res_target, res_mispredict,
    output pred_taken
  );
endinterface

// File: rtl/flag_cond_unit.sv
// flag_cond_unit: multi-set flag file plus a condition resolver with a
// one-entry registered valid/ready output stage.
// - Jumps evaluate a stored flag set. A same-cycle write to that set
//   bypasses into the read.
// - Fused compare-branches evaluate the live req_flags.
// Optional macro FLAG_BHT_EN adds a table of 2-bit saturating counters
// indexed by req_pc. Without it, prediction is static not-taken.
module flag_cond_unit
  import flag_cond_pkg::*;
#(
  parameter int NUM_FSETS = 4,
  parameter int FS_IDX_W  = (NUM_FSETS > 1) ? $clog2(NUM_FSETS) : 1,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16
) (
  input logic              CLK,
  input logic              rst_n,
  flag_cond_unit_if.slave  fc
);

  localparam int BHT_IDX_W = $clog2(BHT_DEPTH);
  localparam logic [FS_IDX_W:0] NSETS = (FS_IDX_W + 1)'(NUM_FSETS);

  FLAGS_t          flag_set [NUM_FSETS];
  FLAGS_t          jump_flags;
  FLAGS_t          sel_flags;
  logic            mode_ok;
  logic            cond_true;
  logic            taken;
  logic            pred;
  logic            mispredict;
  logic            accept;
  logic            wr_in_range;
  logic            rd_in_range;
  logic            res_valid_q;
  logic            res_taken_q;
  logic [PC_W-1:0] res_target_q;
  logic            res_mispredict_q;

  // Evaluates condition code c against flag word f; undefined codes are false.
  function automatic logic cond_eval(input logic [`COND_WIRENUM-1:0] c,
                                     input FLAGS_t f);
    logic r;
    r = 1'b0;
    case (c)
      `COND_NOP: r = 1'b1;
      `COND_E:   r = f.zf;
      `COND_NE:  r = ~f.zf;
      `COND_A:   r = ~f.cf & ~f.zf;
      `COND_B:   r = f.cf;
      `COND_AE:  r = ~f.cf;
      `COND_BE:  r = f.cf | f.zf;
      `COND_G:   r = (f.sf == f.of) & ~f.zf;
      `COND_L:   r = (f.sf != f.of);
      `COND_GE:  r = (f.sf == f.of);
      `COND_LE:  r = (f.sf != f.of) | f.zf;
      `COND_S:   r = f.sf;
      `COND_NS:  r = ~f.sf;
      `COND_O:   r = f.of;
      `COND_NO:  r = ~f.of;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  assign wr_in_range  = ({1'b0, fc.flags_wr_idx} < NSETS);
  assign rd_in_range  = ({1'b0, fc.req_fidx} < NSETS);
  assign accept       = fc.req_valid & fc.req_ready;
  assign fc.req_ready = ~res_valid_q | fc.res_ready;

  // Flag file: the ALU writes are never blocked by jumps or branches.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FSETS; i++) flag_set[i] <= '0;
    end else if (fc.flags_wr && wr_in_range) begin
      flag_set[fc.flags_wr_idx] <= fc.flags_in;
    end
  end

  // Jump read port with same-cycle write bypass.
  always_comb begin
    jump_flags = '0;
    if (fc.flags_wr && wr_in_range && (fc.flags_wr_idx == fc.req_fidx))
      jump_flags = fc.flags_in;
    else if (rd_in_range)
      jump_flags = flag_set[fc.req_fidx];
  end

  // Mode select: jump uses stored flags, branch uses live flags, others never take.
  always_comb begin
    sel_flags = '0;
    mode_ok   = 1'b0;
    case ({fc.req_jump, fc.req_branch})
      2'b10: begin
        sel_flags = jump_flags;
        mode_ok   = 1'b1;
      end
      2'b01: begin
        sel_flags = fc.req_flags;
        mode_ok   = 1'b1;
      end
      default: begin
        sel_flags = '0;
        mode_ok   = 1'b0;
      end
    endcase
  end

  assign cond_true = cond_eval(fc.req_cond, sel_flags);
  assign taken     = mode_ok & cond_true;

`ifdef FLAG_BHT_EN
  logic [1:0]           bht [BHT_DEPTH];
  logic [BHT_IDX_W-1:0] bht_idx;
  logic                 unused_pc_bits;

  assign bht_idx        = fc.req_pc[BHT_IDX_W+1:2];
  assign pred           = bht[bht_idx][1];
  assign mispredict     = (pred != taken);
  assign unused_pc_bits = ^{fc.req_pc[PC_W-1:BHT_IDX_W+2], fc.req_pc[1:0]};

  // Saturating counter training on every accepted jump or branch.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (accept && (fc.req_jump ^ fc.req_branch)) begin
      if (taken) begin
        if (bht[bht_idx] != 2'b11) bht[bht_idx] <= bht[bht_idx] + 2'd1;
      end else begin
        if (bht[bht_idx] != 2'b00) bht[bht_idx] <= bht[bht_idx] - 2'd1;
      end
    end
  end
`else
  logic unused_pc_bits;

  assign pred           = 1'b0;
  assign mispredict     = taken;
  assign unused_pc_bits = ^fc.req_pc ^ BHT_IDX_W[0];
`endif

  assign fc.pred_taken = pred;

  // Output stage: load on accept, drain (and clear taken) when consumed.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_target_q     <= '0;
      res_mispredict_q <= 1'b0;
    end else if (accept) begin
      res_valid_q      <= 1'b1;
      res_taken_q      <= taken;
      res_target_q     <= fc.req_target;
      res_mispredict_q <= mispredict;
    end else if (fc.res_ready) begin
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
    end
  end

  assign fc.res_valid      = res_valid_q;
  assign fc.res_taken      = res_taken_q;
  assign fc.res_target     = res_target_q;
  assign fc.res_mispredict = res_mispredict_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed testbench for flag_cond_unit (default build and FLAG_BHT_EN build).
module tb_flag_cond_unit;
  import flag_cond_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  flag_cond_unit_if #(.NUM_FSETS(4), .PC_W(32)) fc_if ();

  flag_cond_unit #(
    .NUM_FSETS(4),
    .PC_W(32),
    .BHT_DEPTH(16)
  ) dut (
    .CLK  (clk),
    .rst_n(rst_n),
    .fc   (fc_if.slave)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  function automatic FLAGS_t mk(input logic zf, input logic cf, input logic sf,
                                input logic of);
    FLAGS_t f;
    f.zf = zf; f.cf = cf; f.sf = sf; f.of = of;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    fc_if.flags_wr     = 1'b0;
    fc_if.flags_wr_idx = '0;
    fc_if.flags_in     = '0;
    fc_if.req_valid    = 1'b0;
    fc_if.req_jump     = 1'b0;
    fc_if.req_branch   = 1'b0;
    fc_if.req_cond     = '0;
    fc_if.req_fidx     = '0;
    fc_if.req_flags    = '0;
    fc_if.req_pc       = '0;
    fc_if.req_target   = '0;
  endtask

  task automatic drive_req(input logic j, input logic b, input logic [3:0] cond,
                           input logic [1:0] fidx, input FLAGS_t fl,
                           input logic [31:0] tgt, input logic [31:0] pc);
    fc_if.req_valid  = 1'b1;
    fc_if.req_jump   = j;
    fc_if.req_branch = b;
    fc_if.req_cond   = cond;
    fc_if.req_fidx   = fidx;
    fc_if.req_flags  = fl;
    fc_if.req_target = tgt;
    fc_if.req_pc     = pc;
  endtask

  task automatic drive_wr(input logic [1:0] idx, input FLAGS_t f);
    fc_if.flags_wr     = 1'b1;
    fc_if.flags_wr_idx = idx;
    fc_if.flags_in     = f;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    fc_if.res_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({fc_if.res_valid, fc_if.res_taken, fc_if.res_mispredict} !== 3'b000)
      $display("FAIL reset_flags: valid/taken/mispredict=%b expected 000",
               {fc_if.res_valid, fc_if.res_taken, fc_if.res_mispredict});
    else n_pass++;
    n_checks++;
    if (fc_if.res_target !== 32'h0)
      $display("FAIL reset_target: got %h expected 0", fc_if.res_target);
    else n_pass++;
    n_checks++;
    if ({fc_if.req_ready, fc_if.pred_taken} !== 2'b10)
      $display("FAIL reset_ready_pred: got %b expected 10", {fc_if.req_ready, fc_if.pred_taken});
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_jump();
    drive_wr(2'd2, mk(1, 0, 0, 0));
    tick();
    drive_idle();
    drive_req(1, 0, `COND_E, 2'd2, '0, 32'h100, 32'h0);
    tick();
    n_checks++;
    if ({fc_if.res_valid, fc_if.res_taken} !== 2'b11 || fc_if.res_target !== 32'h100)
      $display("FAIL jump_set2_e: valid/taken=%b target=%h expected 11 / 100",
               {fc_if.res_valid, fc_if.res_taken}, fc_if.res_target);
    else n_pass++;
    drive_req(1, 0, `COND_E, 2'd1, '0, 32'h200, 32'h0);
    tick();
    n_checks++;
    if ({fc_if.res_valid, fc_if.res_taken} !== 2'b10 || fc_if.res_target !== 32'h200)
      $display("FAIL jump_set1_e: valid/taken=%b target=%h expected 10 / 200",
               {fc_if.res_valid, fc_if.res_taken}, fc_if.res_target);
    else n_pass++;
    // Set 0 is still zero from reset, so NE is taken.
    drive_req(1, 0, `COND_NE, 2'd0, '0, 32'h300, 32'h0);
    tick();
    n_checks++;
    if ({fc_if.res_valid, fc_if.res_taken} !== 2'b11)
      $display("FAIL jump_set0_ne: valid/taken=%b expected 11", {fc_if.res_valid, fc_if.res_taken});
    else n_pass++;
    drive_idle();
    tick();
    n_checks++;
    if ({fc_if.res_valid, fc_if.res_taken} !== 2'b00)
      $display("FAIL drain_idle: valid/taken=%b expected 00", {fc_if.res_valid, fc_if.res_taken});
    else n_pass++;
  endtask

  task automatic test_bypass();
    drive_wr(2'd3, mk(0, 0, 1, 0));
    drive_req(1, 0, `COND_L, 2'd3, '0, 32'h400, 32'h0);
    tick();
    fc_if.flags_wr = 1'b0;
    n_checks++;
    if ({fc_if.res_valid, fc_if.res_taken} !== 2'b11)
      $display("FAIL bypass_l: valid/taken=%b expected 11", {fc_if.res_valid, fc_if.res_taken});
    else n_pass++;
    drive_req(1, 0, `COND_S, 2'd3, '0, 32'h404, 32'h0);
    tick();
    n_checks++;
    if (fc_if.res_taken !== 1'b1)
      $display("FAIL set3_stored_s: taken=%b expected 1", fc_if.res_taken);
    else n_pass++;
    drive_req(1, 0, `COND_GE, 2'd3, '0, 32'h408, 32'h0);
    tick();
    n_checks++;
    if ({fc_if.res_valid, fc_if.res_taken} !== 2'b10)
      $display("FAIL set3_stored_ge: valid/taken=%b expected 10", {fc_if.res_valid, fc_if.res_taken});
    else n_pass++;
    drive_idle();
    tick();
  endtask

  task automatic test_branch();
    // Flag nibble is {zf,cf,sf,of}.
    logic [3:0] bt_cond [14];
    logic [3:0] bt_fl   [14];
    logic       bt_exp  [14];
    bt_cond = '{`COND_G, `COND_G, `COND_A, `COND_A, `COND_BE, `COND_LE, `COND_GE,
                `COND_O, `COND_NO, `COND_B, `COND_AE, `COND_NS, 4'd15, `COND_NOP};
    bt_fl   = '{4'b0011, 4'b1011, 4'b0000, 4'b0100, 4'b0100, 4'b0001, 4'b0001,
                4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0010, 4'b1111, 4'b0000};
    bt_exp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      drive_req(0, 1, bt_cond[i], 2'd2, FLAGS_t'(bt_fl[i]), 32'h500 + 32'(i), 32'h0);
      tick();
      n_checks++;
      if ({fc_if.res_valid, fc_if.res_taken} !== {1'b1, bt_exp[i]} ||
          fc_if.res_target !== 32'h500 + 32'(i))
        $display("FAIL branch_vec%0d: valid/taken=%b target=%h expected 1%b / %h",
                 i, {fc_if.res_valid, fc_if.res_taken}, fc_if.res_target,
                 bt_exp[i], 32'h500 + 32'(i));
      else n_pass++;
    end
    // Set 2 must still hold ZF=1 after all those branches.
    drive_req(1, 0, `COND_E, 2'd2, '0, 32'h600, 32'h0);
    tick();
    n_checks++;
    if (fc_if.res_taken !== 1'b1)
      $display("FAIL branch_no_write: taken=%b expected 1", fc_if.res_taken);
    else n_pass++;
    drive_idle();
    tick();
  endtask

  task automatic test_backpressure();
    drive_req(1, 0, `COND_E, 2'd2, '0, 32'h0A0, 32'h0);
    tick();
    fc_if.res_ready = 1'b0;
    // Pending request reads set 1, which is rewritten during the stall.
    drive_req(1, 0, `COND_E, 2'd1, '0, 32'h0B0, 32'h0);
    drive_wr(2'd1, mk(1, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if ({fc_if.req_ready, fc_if.res_valid, fc_if.res_taken} !== 3'b011 ||
          fc_if.res_target !== 32'h0A0)
        $display("FAIL stall_cyc%0d: ready/valid/taken=%b target=%h expected 011 / 0a0",
                 i, {fc_if.req_ready, fc_if.res_valid, fc_if.res_taken}, fc_if.res_target);
      else n_pass++;
      tick();
      fc_if.flags_wr = 1'b0;
    end
    fc_if.res_ready = 1'b1;
    #1;
    n_checks++;
    if (fc_if.req_ready !== 1'b1)
      $display("FAIL release_ready: req_ready=%b expected 1", fc_if.req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if ({fc_if.res_valid, fc_if.res_taken} !== 2'b11 || fc_if.res_target !== 32'h0B0)
      $display("FAIL release_result: valid/taken=%b target=%h expected 11 / 0b0",
               {fc_if.res_valid, fc_if.res_taken}, fc_if.res_target);
    else n_pass++;
    drive_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    // Branch E with ZF = i[0]: odd requests taken.
    for (int i = 0; i < 8; i++) begin
      drive_req(0, 1, `COND_E, 2'd0, mk(i[0], 0, 0, 0), 32'h1000 + 32'(i * 4), 32'h0);
      tick();
      n_checks++;
      if ({fc_if.res_valid, fc_if.res_taken} !== {1'b1, i[0]} ||
          fc_if.res_target !== 32'h1000 + 32'(i * 4))
        $display("FAIL b2b_%0d: valid/taken=%b target=%h expected 1%b / %h",
                 i, {fc_if.res_valid, fc_if.res_taken}, fc_if.res_target, i[0],
                 32'h1000 + 32'(i * 4));
      else n_pass++;
    end
    drive_req(1, 1, `COND_NOP, 2'd2, mk(1, 1, 1, 1), 32'h2000, 32'h0);
    tick();
    n_checks++;
    if ({fc_if.res_valid, fc_if.res_taken} !== 2'b10 || fc_if.res_target !== 32'h2000)
      $display("FAIL both_modes: valid/taken=%b target=%h expected 10 / 2000",
               {fc_if.res_valid, fc_if.res_taken}, fc_if.res_target);
    else n_pass++;
    drive_idle();
    tick();
    n_checks++;
    if (fc_if.res_valid !== 1'b0)
      $display("FAIL b2b_drain: valid=%b expected 0", fc_if.res_valid);
    else n_pass++;
  endtask

  task automatic test_predict();
`ifdef FLAG_BHT_EN
    logic exp_pred [4];
    logic exp_mis  [4];
    logic [3:0] cnd [4];
    exp_pred = '{1'b0, 1'b1, 1'b1, 1'b1};
    exp_mis  = '{1'b1, 1'b0, 1'b0, 1'b1};
    cnd      = '{`COND_NOP, `COND_NOP, `COND_NOP, `COND_E};
    for (int i = 0; i < 4; i++) begin
      drive_req(0, 1, cnd[i], 2'd0, mk(0, 0, 0, 0), 32'h3000, 32'h84);
      #1;
      n_checks++;
      if (fc_if.pred_taken !== exp_pred[i])
        $display("FAIL bht_pred%0d: pred_taken=%b expected %b", i, fc_if.pred_taken, exp_pred[i]);
      else n_pass++;
      tick();
      n_checks++;
      if (fc_if.res_mispredict !== exp_mis[i])
        $display("FAIL bht_mis%0d: mispredict=%b expected %b", i, fc_if.res_mispredict, exp_mis[i]);
      else n_pass++;
    end
`else
    drive_req(0, 1, `COND_NOP, 2'd0, '0, 32'h3000, 32'h84);
    #1;
    n_checks++;
    if (fc_if.pred_taken !== 1'b0)
      $display("FAIL static_pred: pred_taken=%b expected 0", fc_if.pred_taken);
    else n_pass++;
    tick();
    n_checks++;
    if (fc_if.res_mispredict !== 1'b1)
      $display("FAIL static_mis_taken: mispredict=%b expected 1", fc_if.res_mispredict);
    else n_pass++;
    drive_req(0, 1, `COND_E, 2'd0, '0, 32'h3004, 32'h84);
    tick();
    n_checks++;
    if (fc_if.res_mispredict !== 1'b0)
      $display("FAIL static_mis_not: mispredict=%b expected 0", fc_if.res_mispredict);
    else n_pass++;
`endif
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive_req(0, 1, `COND_NOP, 2'd0, '0, 32'h4000, 32'h84);
    tick();
    fc_if.res_ready = 1'b0;
    drive_idle();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fc_if.res_valid, fc_if.res_taken} !== 2'b00)
      $display("FAIL async_reset: valid/taken=%b expected 00", {fc_if.res_valid, fc_if.res_taken});
    else n_pass++;
    tick();
    rst_n = 1'b1;
    fc_if.res_ready = 1'b1;
    // Set 2 was cleared by reset, so NE is taken.
    drive_req(1, 0, `COND_NE, 2'd2, '0, 32'h4100, 32'h0);
    tick();
    n_checks++;
    if (fc_if.res_taken !== 1'b1)
      $display("FAIL reset_cleared_set2: taken=%b expected 1", fc_if.res_taken);
    else n_pass++;
`ifdef FLAG_BHT_EN
    // Counter for pc 0x84 back at 01: predicts 0, then 1 after one taken.
    drive_req(0, 1, `COND_NOP, 2'd0, '0, 32'h4200, 32'h84);
    #1;
    n_checks++;
    if (fc_if.pred_taken !== 1'b0)
      $display("FAIL bht_reset_pred0: pred_taken=%b expected 0", fc_if.pred_taken);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (fc_if.pred_taken !== 1'b1)
      $display("FAIL bht_reset_pred1: pred_taken=%b expected 1", fc_if.pred_taken);
    else n_pass++;
`endif
    drive_idle();
    tick();
  endtask

  // Sequencer and final report.
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    test_reset();
    test_jump();
    test_bypass();
    test_branch();
    test_backpressure();
    test_back_to_back();
    test_predict();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
